axi_master_arb: RTL
===================

# axi_master_arb

Parametrised N-port arbiter and bridge from simple single-beat CPU-side request ports (IFU, LSU, future DMA/debug) onto one AXI4 master port. It generalises the fixed IFU/LSU sequencer with configurable port count, data width and round-robin fairness. It also adds the write-response (B) phase, per-port read-data and error return, and ID checking. It sits between the core's fetch/memory units and the `io_master` SoC bus.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requester ports; port index is also the AXI ID.
- `DATA_W`, 32: data width, 32 or 64; strobe width is `DATA_W/8`.
- `ADDR_W`, 32: address width.
- `ID_W`, 4: AXI ID width; requires `NUM_PORTS <= 2**ID_W`.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in N: per-port request valid.
- `req_ready` out N: one-hot accept.
- `req_write` in N: 1 = write.
- `req_addr` in N*ADDR_W: packed, port i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata` in N*DATA_W: packed write data.
- `req_wstrb` in N*DATA_W/8: packed byte strobes.
- `req_size` in N*3: AXI size code.
- `rsp_valid` out N: one-hot, one-cycle completion pulse; no backpressure.
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid`.
- `rsp_err` out 1: error flag, valid with `rsp_valid`.
- `io_master_*`: AXI4 AW/W/B/AR/R channels at widths `ADDR_W`, `DATA_W`, `ID_W`.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE, with any `req_valid` set:
  - Pick the grant port round-robin, searching from `last_grant+1` modulo N.
  - Assert `req_ready[grant]` combinationally in the same cycle.
  - Latch addr, wdata, wstrb, size, write and grant.
  - Go to WR_REQ if write, otherwise RD_ADDR.
- RD_ADDR:
  - `arvalid=1` with the latched addr/size and `arid=grant`.
  - Go to RD_DATA on `arready`.
- RD_DATA:
  - `rready=1`.
  - On `rvalid`: register rdata and `err = rresp[1] | (rid!=grant) | !rlast`, then go to IDLE.
- WR_REQ:
  - `awvalid` and `wvalid` are both raised on entry.
  - Each drops independently after its own handshake.
  - `wlast=1` whenever `wvalid=1`.
  - Go to WR_RESP once both handshakes are done, including both in the same cycle.
- WR_RESP:
  - `bready=1`.
  - On `bvalid`: register `err = bresp[1] | (bid!=grant)`, then go to IDLE.
- Completion: `rsp_valid[grant]` pulses the cycle after the R/B handshake. `rsp_rdata` is zero for writes.
- Fixed AXI fields: `awlen=arlen=0`, `burst=INCR`.
- Only one transaction is outstanding at a time. Reads and writes are never overlapped.
- `last_grant` updates on every grant.

## Timing
- Reset values: state=IDLE, `last_grant=N-1` (so port 0 wins first). All valid/ready outputs are 0, `rsp_rdata=0`, `rsp_err=0`.
- Reset mid-transaction: outputs drop asynchronously and the transaction is abandoned. The SoC bus is also reset.
- Read with zero-wait slave: accept at cycle 0, `arvalid` cycle 1, `rready` cycle 2, `rsp_valid` cycle 3. The next grant can occur in cycle 3.
- Write with zero-wait slave: accept at cycle 0, AW+W cycle 1, `bready` cycle 2, `rsp_valid` cycle 3.
- AXI valids are held stable, with payload unchanged, until handshake.
- `req_ready` is never asserted outside IDLE. `req_*` inputs are sampled only in the accept cycle.
- Simultaneous requests: exactly one `req_ready` bit is set. A requester holding valid is served within N transactions.

## Structure
- Package `axi_pkg`:
  - burst/resp/size localparams (`BURST_INCR`, `RESP_SLVERR` bit).
  - the state enum.
- Sub-module `rr_arbiter`:
  - parameter N.
  - inputs `req` and `last`; outputs one-hot `gnt` and index `gnt_idx`.
  - purely combinational rotate-priority.
- Top level holds the FSM, payload registers and AXI drive.

## Test plan
- Single read, port 1, addr 0x8000_0004, slave returns 0xDEADBEEF with OKAY on the first cycle -> `arid=1`; `rsp_valid=0b10` in cycle 3; `rsp_rdata=0xDEADBEEF`; `rsp_err=0`.
- Write, port 0, addr 0x1000, wdata 0x12345678, wstrb 0xF. Slave delays `awready` 3 cycles and accepts W immediately -> `wvalid` drops after 1 cycle while `awvalid` is held; `bresp=SLVERR` gives `rsp_err=1`.
- All N ports hold `req_valid` for 2N grants -> grant order 0,1,...,N-1,0,... with no port skipped.
- Read with `rid=3` mismatching grant 0, or with `rlast=0` -> `rsp_err=1`.
- Assert reset in RD_DATA -> `rready`/`arvalid` go to 0 immediately with no clock edge; after release, port 0 is granted first.
- `DATA_W=64`: 8-bit strobe 0xF0 and 64-bit rdata pass through unaltered.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI field encodings and arbiter FSM states.
// Revision    : 1.0
// ============================================================================
package axi_pkg;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam int         RESP_SLVERR     = 1;      // bresp/rresp bit that flags SLVERR/DECERR
    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arb_if
// Description : AXI4 master bus (AW/W/B/AR/R) with master/slave views.
// Revision    : 1.0
// ============================================================================
interface axi_master_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();

    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority arbiter, search starts at last+1.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int   k;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 1; i <= N; i++) begin
            k = int'(last) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found      = 1'b1;
                gnt[k]     = 1'b1;
                gnt_idx    = k[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arb
// Description : N-port round-robin single-beat request bridge onto AXI4 master.
// Revision    : 1.0
// ============================================================================
module axi_master_arb
    import axi_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
    input  logic [NUM_PORTS*3-1:0]        req_size,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    axi_master_arb_if.master              io_master
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int STRB_W = DATA_W / 8;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       r_grant;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [2:0]             r_size;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_bready;
    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;

    logic [NUM_PORTS-1:0]   w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_aw_done;
    logic                   w_w_done;
    logic                   w_unused_ok;

    rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_rr_arbiter (
        .req     (req_valid),
        .last    (r_last_grant),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign req_ready = (r_state == ST_IDLE && reset) ? w_gnt : '0;

    assign w_aw_done = !r_awvalid || io_master.awready;
    assign w_w_done  = !r_wvalid  || io_master.wready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(NUM_PORTS - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_size       <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_bready     <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_addr       <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                        r_wdata      <= req_wdata[w_gnt_idx*DATA_W +: DATA_W];
                        r_wstrb      <= req_wstrb[w_gnt_idx*STRB_W +: STRB_W];
                        r_size       <= req_size[w_gnt_idx*3 +: 3];
                        if (req_write[w_gnt_idx]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (io_master.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (io_master.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= io_master.rdata;
                        r_rsp_err   <= io_master.rresp[RESP_SLVERR]
                                     | (io_master.rid != ID_W'(r_grant))
                                     | !io_master.rlast;
                        r_rsp_valid <= NUM_PORTS'(1) << r_grant;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (r_awvalid && io_master.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && io_master.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (io_master.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= io_master.bresp[RESP_SLVERR]
                                     | (io_master.bid != ID_W'(r_grant));
                        r_rsp_valid <= NUM_PORTS'(1) << r_grant;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_master.awvalid = r_awvalid;
    assign io_master.awid    = ID_W'(r_grant);
    assign io_master.awaddr  = r_addr;
    assign io_master.awlen   = AXI_LEN_SINGLE;
    assign io_master.awsize  = r_size;
    assign io_master.awburst = BURST_INCR;
    assign io_master.wvalid  = r_wvalid;
    assign io_master.wdata   = r_wdata;
    assign io_master.wstrb   = r_wstrb;
    assign io_master.wlast   = r_wvalid;
    assign io_master.bready  = r_bready;
    assign io_master.arvalid = r_arvalid;
    assign io_master.arid    = ID_W'(r_grant);
    assign io_master.araddr  = r_addr;
    assign io_master.arlen   = AXI_LEN_SINGLE;
    assign io_master.arsize  = r_size;
    assign io_master.arburst = BURST_INCR;
    assign io_master.rready  = r_rready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_unused_ok = ^{io_master.rresp[0], io_master.bresp[0]};

endmodule
`default_nettype wire
